// File: rtl/generador_patrones.sv
// Parametrised test-pattern generator: saturating/wrapping count, PRBS or fixed
// word, advanced every HOLD cycles under READY backpressure, with a one-cycle strobe.
module generador_patrones #(
  parameter int              WIDTH = 10,
  parameter int              HOLD  = 10,
  parameter logic [WIDTH-1:0] TAPS = 10'h240,
  parameter int              CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             strobe_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [1:0]       state_o
);

  // Handshake: a word advances only on an edge where the hold count is
  // terminal and ready_i is high; ready_i low at terminal count parks in STALL
  // with d_o stable until ready_i returns.

  localparam int HCW = $clog2(HOLD + 1);
  localparam logic [HCW-1:0] HOLD_M1 = HCW'(HOLD - 1);

  localparam logic [1:0] MODE_SAT   = 2'b00;
  localparam logic [1:0] MODE_WRAP  = 2'b01;
  localparam logic [1:0] MODE_PRBS  = 2'b10;
  localparam logic [1:0] MODE_FIXED = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  logic [WIDTH-1:0] next_word;
  logic             sat_stop;
  logic             try_adv;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      d_q      <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Pattern successor; mode only matters on an advance edge.
  always_comb begin
    next_word = d_q;
    sat_stop  = 1'b0;
    case (mode_i)
      MODE_SAT: begin
        if (&d_q) sat_stop = 1'b1;
        else      next_word = d_q + WIDTH'(1);
      end
      MODE_WRAP: next_word = d_q + WIDTH'(1);
      MODE_PRBS: begin
        if (d_q == '0) next_word = WIDTH'(1);
        else           next_word = {d_q[WIDTH-2:0], ^(d_q & TAPS)};
      end
      MODE_FIXED: next_word = d_q;
      default:    next_word = d_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    try_adv  = 1'b0;
    if (load_i) begin
      d_d     = seed_i;
      hold_d  = '0;
      cnt_d   = '0;
      state_d = enable_i ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hold_d = '0;
          if (enable_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!enable_i) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (hold_q == HOLD_M1) begin
            if (ready_i) try_adv = 1'b1;
            else         state_d = ST_STALL;
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
        ST_STALL: begin
          if (!enable_i) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (ready_i) begin
            try_adv = 1'b1;
          end
        end
        ST_DONE: begin
          if (!enable_i) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (try_adv) begin
        hold_d = '0;
        if (sat_stop) begin
          state_d = ST_DONE;
        end else begin
          d_d      = next_word;
          strobe_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = ST_RUN;
        end
      end
    end
  end

  always_comb begin
    d_o        = d_q;
    strobe_o   = strobe_q;
    done_o     = (state_q == ST_DONE);
    word_cnt_o = cnt_q;
    state_o    = state_q;
  end

endmodule
